// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD count controller.
//   state_t       : controller FSM encoding (IDLE / RUN / PAUSE)
//   SEG_*         : active-low {g,f,e,d,c,b,a} patterns for digits 0-9 and blank
//   DIG_*         : active-low digit-select codes
//   bcd_inc()     : one-step increment of a 2-digit BCD value (units carry into tens)
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] DIG_UNITS = 2'b10;
    localparam logic [1:0] DIG_TENS  = 2'b01;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_seg7.sv
// Combinational 4-bit digit to 7-segment decoder.
//   digit : 4-bit digit value
//   seg   : active-low segments {g,f,e,d,c,b,a}; values A-F are blanked
module bcd_seg7
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Two-digit BCD up-counter with run/pause/clear control and a multiplexed
// 7-segment display driver.
//   CLK     : clock, rising edge
//   RESET   : asynchronous active-low reset
//   START   : run / resume pulse
//   STOP    : pause pulse
//   CLEAR   : return to idle and zero the count
//   Q       : BCD count {tens, units}
//   RUNNING : high while in RUN
//   WRAP    : one-cycle pulse after the count wraps MAX_BCD -> 00
//   SEG     : active-low segments for the selected digit (registered)
//   DIG     : active-low digit select (10 = units, 01 = tens)
module bcd_count_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000,
    parameter logic [7:0]  MAX_BCD  = 8'h59,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       STOP,
    input  logic       CLEAR,
    output logic [7:0] Q,
    output logic       RUNNING,
    output logic       WRAP,
    output logic [6:0] SEG,
    output logic [1:0] DIG
);

    localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned   SW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    state_t        state, state_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [7:0]    q_nx;
    logic          wrap_nx;
    logic          tick;
    logic [SW-1:0] scan_cnt, scan_cnt_nx;
    logic          scan_sel, scan_sel_nx;
    logic [3:0]    digit_nx;
    logic [6:0]    seg_nx;

    // Controller next state: CLEAR beats everything (including a coincident
    // tick); a tick coinciding with STOP is still applied.
    always_comb begin
        state_nx = state;
        presc_nx = presc;
        q_nx     = Q;
        wrap_nx  = 1'b0;
        tick     = (state == RUN) && (presc == PRESC_LAST);
        if (CLEAR) begin
            state_nx = IDLE;
            presc_nx = '0;
            q_nx     = '0;
        end else begin
            if (tick) begin
                presc_nx = '0;
                if (Q == MAX_BCD) begin
                    q_nx    = '0;
                    wrap_nx = 1'b1;
                end else begin
                    q_nx = bcd_inc(Q);
                end
            end else if (state == RUN) begin
                presc_nx = presc + PW'(1);
            end
            if (STOP) begin
                if (state == RUN) begin
                    state_nx = PAUSE;
                end
            end else if (START && (state != RUN)) begin
                state_nx = RUN;
            end
        end
    end

    // Scan counter runs regardless of state. SEG is decoded from the
    // next-cycle digit select and count so it lines up with DIG and Q.
    always_comb begin
        scan_cnt_nx = scan_cnt + SW'(1);
        scan_sel_nx = scan_sel;
        if (scan_cnt == SCAN_LAST) begin
            scan_cnt_nx = '0;
            scan_sel_nx = ~scan_sel;
        end
        digit_nx = scan_sel_nx ? q_nx[7:4] : q_nx[3:0];
    end

    bcd_seg7 u_seg7 (
        .digit (digit_nx),
        .seg   (seg_nx)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            presc    <= '0;
            Q        <= '0;
            WRAP     <= 1'b0;
            scan_cnt <= '0;
            scan_sel <= 1'b0;
            DIG      <= DIG_UNITS;
            SEG      <= SEG_0;
        end else begin
            state    <= state_nx;
            presc    <= presc_nx;
            Q        <= q_nx;
            WRAP     <= wrap_nx;
            scan_cnt <= scan_cnt_nx;
            scan_sel <= scan_sel_nx;
            DIG      <= scan_sel_nx ? DIG_TENS : DIG_UNITS;
            SEG      <= seg_nx;
        end
    end

    always_comb begin
        RUNNING = (state == RUN);
    end

endmodule
